// File: rtl/la_ckpt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : la_ckpt_pkg                                            |
// | Description : Shared constants for the checkpoint scheduler: FSM     |
// |               state encoding, grant index width, default idle word   |
// |               and the round-robin pointer advance helper.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package la_ckpt_pkg;

  // Width of grant_id / round-robin pointer (covers up to 8 requesters)
  localparam int GRANT_W = 3;

  // Scheduler state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  // Pad value while no checkpoint word is being held
  localparam logic [15:0] IDLE_WORD_DEFAULT = 16'h0000;

  // Pointer to the requester after 'id', wrapping at nreq
  function automatic logic [GRANT_W-1:0] rr_next_ptr(
    input logic [GRANT_W-1:0] id,
    input int                 nreq
  );
    logic [GRANT_W-1:0] nxt;
    nxt = id + 1'b1;
    if ((int'(id) + 1) >= nreq) begin
      nxt = '0;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/la_ckpt_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : la_ckpt_rr_arb                                         |
// | Description : Combinational round-robin pick. Starting at 'ptr' and  |
// |               searching upward with wrap, the first asserted request |
// |               wins; reports it one-hot, as an index, and whether any |
// |               request was present at all.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module la_ckpt_rr_arb
  import la_ckpt_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NREQ-1:0]    onehot,
  output logic [GRANT_W-1:0] idx,
  output logic               any_req
);

  // Walk offsets 0..NREQ-1 from the pointer; the first requester hit wins
  always_comb begin
    onehot  = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_req && req[j] && (((int'(ptr) + k) % NREQ) == j)) begin
          any_req   = 1'b1;
          onehot[j] = 1'b1;
          idx       = GRANT_W'(j);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/la_checkpoint_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : la_checkpoint_sched                                    |
// | Description : Time-shares the checkpoint field on mprj_io[31:16]     |
// |               between NREQ requesters. A granted word is captured    |
// |               once, held on the pads for HOLD_CYCLES clocks, the     |
// |               requester is acked, then the pads idle for GAP_CYCLES. |
// |               Optional macro LA_CKPT_PRIO0_EN: requester 0 wins every|
// |               arbitration it takes part in and does not move the     |
// |               round-robin pointer.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module la_checkpoint_sched
  import la_ckpt_pkg::*;
#(
  parameter int               NREQ        = 4,
  parameter int               WIDTH       = 16,
  parameter int               HOLD_CYCLES = 8,
  parameter int               GAP_CYCLES  = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(IDLE_WORD_DEFAULT)
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      io_out,
  output logic [WIDTH-1:0]      io_oeb,
  output logic                  busy,
  output logic [GRANT_W-1:0]    grant_id
);

  // Hold counter sized for HOLD_CYCLES-1 down to 0; gap counter likewise
  localparam int c_hcnt_w = $clog2(HOLD_CYCLES + 1);
  localparam int c_gcnt_w = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_hcnt_w-1:0] c_hold_load = c_hcnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_gcnt_w-1:0] c_gap_load  =
    c_gcnt_w'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  // Registered state
  logic [1:0]          r_state;
  logic [GRANT_W-1:0]  r_ptr;
  logic [GRANT_W-1:0]  r_grant_id;
  logic [NREQ-1:0]     r_grant_oh;
  logic [WIDTH-1:0]    r_word;
  logic [WIDTH-1:0]    r_io_out;
  logic [WIDTH-1:0]    r_oeb;
  logic [NREQ-1:0]     r_ack;
  logic                r_busy;
  logic [c_hcnt_w-1:0] r_hcnt;
  logic [c_gcnt_w-1:0] r_gcnt;

  // Arbitration results
  logic [NREQ-1:0]     w_arb_oh;
  logic [GRANT_W-1:0]  w_arb_idx;
  logic                w_arb_any;
  logic [NREQ-1:0]     w_win_oh;
  logic [GRANT_W-1:0]  w_win_idx;
  logic [WIDTH-1:0]    w_win_word;

  la_ckpt_rr_arb #(
    .NREQ    (NREQ)
  ) u_arb (
    .req     (req),
    .ptr     (r_ptr),
    .onehot  (w_arb_oh),
    .idx     (w_arb_idx),
    .any_req (w_arb_any)
  );

  // Final winner: round-robin pick, optionally overridden by requester 0
  always_comb begin
    w_win_oh  = w_arb_oh;
    w_win_idx = w_arb_idx;
`ifdef LA_CKPT_PRIO0_EN
    if (req[0]) begin
      w_win_oh  = NREQ'(1);
      w_win_idx = '0;
    end
`endif
  end

  // Word of the winning requester, selected through its one-hot grant
  always_comb begin
    w_win_word = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_win_oh[j]) begin
        w_win_word = req_data[j*WIDTH +: WIDTH];
      end
    end
  end

  // Scheduler FSM: capture in IDLE, drive in LOAD, count out HOLD and GAP
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_grant_oh <= '0;
      r_word     <= IDLE_WORD;
      r_io_out   <= IDLE_WORD;
      r_oeb      <= '1;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_hcnt     <= '0;
      r_gcnt     <= '0;
    end else begin
      // Pads are enabled from the first clock after reset release onward
      r_oeb <= '0;
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_grant_id <= w_win_idx;
            r_grant_oh <= w_win_oh;
            r_word     <= w_win_word;
            r_busy     <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_io_out <= r_word;
          r_hcnt   <= c_hold_load;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (r_hcnt == '0) begin
            r_ack    <= r_grant_oh;
            r_io_out <= IDLE_WORD;
`ifdef LA_CKPT_PRIO0_EN
            // A requester-0 grant leaves the rotation where it was
            if (r_grant_id != '0) begin
              r_ptr <= rr_next_ptr(r_grant_id, NREQ);
            end
`else
            r_ptr <= rr_next_ptr(r_grant_id, NREQ);
`endif
            if (GAP_CYCLES > 0) begin
              r_gcnt  <= c_gap_load;
              r_state <= GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_hcnt <= r_hcnt - 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gcnt <= r_gcnt - 1'b1;
          end
        end
        default: begin
          r_io_out <= IDLE_WORD;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign io_out   = r_io_out;
  assign io_oeb   = r_oeb;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_la_checkpoint_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_la_checkpoint_sched                                 |
// | Description : Self-checking bench for la_checkpoint_sched. A         |
// |               timeline reference model predicts every output each    |
// |               cycle; a vector table checks grant order; hand-written |
// |               sequences cover latency, capture, fairness and reset.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_la_checkpoint_sched;
  import la_ckpt_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int HOLD  = 8;
  localparam int GAPC  = 2;
  localparam logic [15:0] IDLEW = 16'h0000;

  logic                  clock = 1'b0;
  logic                  resetb = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      io_out;
  logic [WIDTH-1:0]      io_oeb;
  logic                  busy;
  logic [GRANT_W-1:0]    grant_id;

  la_checkpoint_sched #(
    .NREQ        (NREQ),
    .WIDTH       (WIDTH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAPC),
    .IDLE_WORD   (IDLEW)
  ) dut (
    .clock    (clock),
    .resetb   (resetb),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: grant timeline ----------------
  // A grant sampled at edge S puts its word on the pads after edges
  // S+1..S+HOLD, acks after edge S+HOLD+1, keeps busy through S+HOLD+GAP,
  // and the next grant may be sampled at edge S+HOLD+GAP+2.
  int          m_n = 0;
  int          m_ptr = 0;
  int          m_gid = 0;
  int          m_start = 0;
  int          m_free = 1;
  int          m_w = 0;
  bit          m_active = 1'b0;
  logic [15:0] m_word = IDLEW;

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      m_n = 0; m_ptr = 0; m_gid = 0; m_start = 0; m_free = 1;
      m_active = 1'b0; m_word = IDLEW;
    end else begin
      m_n++;
      if (m_active && m_n == m_start + HOLD + 1) begin
`ifdef LA_CKPT_PRIO0_EN
        if (m_gid != 0) m_ptr = (m_gid + 1) % NREQ;
`else
        m_ptr = (m_gid + 1) % NREQ;
`endif
      end
      if (m_n >= m_free && req != '0) begin
        m_w = -1;
`ifdef LA_CKPT_PRIO0_EN
        if (req[0]) m_w = 0;
`endif
        for (int k = 0; k < NREQ; k++)
          if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
        m_gid    = m_w;
        m_start  = m_n;
        m_active = 1'b1;
        m_word   = req_data[m_w*WIDTH +: WIDTH];
        m_free   = m_n + HOLD + GAPC + 2;
      end
    end
  end

  // Compare every output against the model once per cycle
  always @(negedge clock) begin
    check("io_out", 32'(io_out),
          (m_active && m_n >= m_start + 1 && m_n <= m_start + HOLD) ? 32'(m_word) : 32'(IDLEW));
    check("ack", 32'(ack),
          (m_active && m_n == m_start + HOLD + 1) ? (32'd1 << m_gid) : 32'd0);
    check("busy", 32'(busy),
          (m_active && m_n >= m_start && m_n <= m_start + HOLD + GAPC) ? 32'd1 : 32'd0);
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("io_oeb", 32'(io_oeb), (m_n == 0) ? 32'h0000FFFF : 32'd0);
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clock); #2 resetb = 1'b0;
    repeat (2) @(posedge clock);
    #2 resetb = 1'b1;
  endtask

  // Wait (bounded) for an ack pulse; returns requester index or -1
  task automatic wait_ack(output int id, input int budget);
    id = -1;
    for (int c = 0; c < budget && id < 0; c++) begin
      @(negedge clock);
      if (ack != '0)
        for (int b = 0; b < NREQ; b++) if (ack[b] && id < 0) id = b;
    end
  endtask

  task automatic set_words();
    req_data = {16'hAB63, 16'hAB62, 16'hAB61, 16'hAB60};
  endtask

  typedef struct packed {
    logic [3:0]       mask;
    logic [2:0]       n;
    logic [3:0][2:0]  order;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input logic [3:0] m, input int n,
                              input int o0, input int o1, input int o2, input int o3);
    vec_t v;
    v.mask = m; v.n = 3'(n);
    v.order[0] = 3'(o0); v.order[1] = 3'(o1); v.order[2] = 3'(o2); v.order[3] = 3'(o3);
    return v;
  endfunction

  int id;
  int exp_c2 [3];

  initial begin
    tbl[0] = mk(4'b0001, 1, 0, 0, 0, 0);
    tbl[1] = mk(4'b1111, 4, 0, 1, 2, 3);
    tbl[2] = mk(4'b1010, 2, 1, 3, 0, 0);
    tbl[3] = mk(4'b0110, 2, 1, 2, 0, 0);
    tbl[4] = mk(4'b1000, 1, 3, 0, 0, 0);
    tbl[5] = mk(4'b1001, 2, 0, 3, 0, 0);

    // Reset state and release
    repeat (2) @(negedge clock);
    check("rst_oeb", 32'(io_oeb), 32'h0000FFFF);
    check("rst_io", 32'(io_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    @(posedge clock); #2 resetb = 1'b1;
    @(posedge clock); #1;
    check("rel_oeb", 32'(io_oeb), 32'h0);
    check("rel_io", 32'(io_out), 32'h0);
    check("rel_busy", 32'(busy), 32'h0);

    // Latency, hold stability and capture-once behaviour
    @(negedge clock);
    req_data[15:0] = 16'hAB60; req = 4'b0001;
    @(negedge clock); check("lat_load", 32'(io_out), 32'h0);
    @(negedge clock); check("lat_word", 32'(io_out), 32'hAB60);
    req_data[15:0] = 16'hFFFF; req = 4'b0000;
    for (int c = 0; c < HOLD - 2; c++) begin
      @(negedge clock); check("hold_word", 32'(io_out), 32'hAB60);
    end
    wait_ack(id, 10);
    check("capture_ack", 32'(id), 32'd0);
    check("gap_io", 32'(io_out), 32'h0);

    // Grant-order vectors, each from a fresh reset (pointer at 0)
    for (int v = 0; v < 6; v++) begin
      do_reset();
      @(negedge clock);
      set_words();
      req = tbl[v].mask;
      for (int k = 0; k < int'(tbl[v].n); k++) begin
        wait_ack(id, 40);
        check($sformatf("order_v%0d_%0d", v, k), 32'(id), 32'(tbl[v].order[k]));
        if (id >= 0) req[id] = 1'b0;
      end
      req = '0;
    end

    // Fairness: req[2] held, req[1] raised during grant 2 -> 2,1,2
    do_reset();
    @(negedge clock);
    set_words(); req = 4'b0100;
    repeat (2) @(negedge clock);
    req[1] = 1'b1;
    wait_ack(id, 40); check("fair_0", 32'(id), 32'd2);
    wait_ack(id, 40); check("fair_1", 32'(id), 32'd1);
    if (id >= 0) req[id] = 1'b0;
    wait_ack(id, 40); check("fair_2", 32'(id), 32'd2);
    req = '0;

    // Requesters 0 and 2 held continuously
`ifdef LA_CKPT_PRIO0_EN
    exp_c2 = '{0, 0, 0};
`else
    exp_c2 = '{0, 2, 0};
`endif
    do_reset();
    @(negedge clock);
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_ack(id, 40);
      check($sformatf("held02_%0d", k), 32'(id), 32'(exp_c2[k]));
    end
    req = '0;

    // Reset at HOLD count 3 aborts; pending request re-served from 0
    do_reset();
    @(negedge clock);
    set_words(); req = 4'b1001;
    @(negedge clock);
    repeat (4) @(negedge clock);
    @(posedge clock); #2 resetb = 1'b0;
    #1;
    check("abort_io", 32'(io_out), 32'h0);
    check("abort_oeb", 32'(io_oeb), 32'h0000FFFF);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ack", 32'(ack), 32'h0);
    repeat (2) @(posedge clock);
    #2 resetb = 1'b1;
    wait_ack(id, 40); check("reserve_id", 32'(id), 32'd0);
    req = '0;

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      for (int b = 0; b < NREQ; b++) begin
        if (ack[b]) req[b] = 1'b0;
        else if (!req[b] && $urandom_range(0, 7) == 0) req[b] = 1'b1;
        else if (req[b] && $urandom_range(0, 63) == 0) req[b] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
      if (c == 250) do_reset();
    end
    req = '0;
    repeat (30) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1);
  end

endmodule
`default_nettype wire
